multicycle_main_control: RTL and testbench

Multi-cycle main control FSM for the RV32I core. It is the producer side of the ALUOp interface consumed by alu_control. It sequences fetch, decode, execute, memory and writeback for R-type, I-type ALU, LW, SW and BEQ, and drives the datapath mux selects and write enables. It also handshakes with instruction/data memory and traps on illegal opcodes or memory timeout.

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/mem_timeout_counter.sv | 38 +++
 rtl/multicycle_main_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_main_control.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I control constants and main-control state encoding.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp encoding is shared with alu_control.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] TRAP_NONE        = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
  localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_WB_ALU   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_TRAP     = 4'd10
  } state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - counts unanswered memory-request cycles and flags expiry.
module mem_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic expired_o
);

  // A zero limit disables the timeout; keep a 1-bit counter parked at zero.
  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = mem_req_i && !mem_ready_i;

  always_comb begin
    cnt_d = '0;
    if (MEM_TIMEOUT != 0 && waiting) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && waiting && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multi-cycle RV32I main control FSM driving datapath selects and enables.
module multicycle_main_control
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOp,
  output logic       alu_funct7_kill,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       req_phase;
  logic       tmo_expired;

  assign req_phase = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  mem_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timeout (
    .clk        (clk),
    .rst        (rst),
    .mem_req_i  (req_phase),
    .mem_ready_i(mem_ready),
    .expired_o  (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_src          = 1'b0;
    ir_write        = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    iord            = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = SRCB_RS2;
    ALUOp           = ALUOP_ADD;
    alu_funct7_kill = 1'b0;
    reg_write       = 1'b0;
    mem_to_reg      = 1'b0;
    instr_retired   = 1'b0;
    trap            = 1'b0;
    trap_cause      = TRAP_NONE;
    if (!rst) begin
      trap_cause = cause_q;
      case (state_q)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) state_d = ST_DECODE;
        end
        ST_DECODE: begin
          case (opcode)
            OP_R:               state_d = ST_EXEC_R;
            OP_I:               state_d = ST_EXEC_I;
            OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
            OP_BRANCH:          state_d = ST_BRANCH;
            default: begin
              state_d = ST_TRAP;
              cause_d = TRAP_ILLEGAL;
            end
          endcase
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_RS2;
          ALUOp     = ALUOP_FUNCT;
          state_d   = ST_WB_ALU;
        end
        ST_EXEC_I: begin
          alu_src_a       = 1'b1;
          alu_src_b       = SRCB_IMM;
          ALUOp           = ALUOP_FUNCT;
          // ADDI has no SUB form: imm[11:5] must not look like funct7.
          alu_funct7_kill = (funct3 == 3'b000);
          state_d         = ST_WB_ALU;
        end
        ST_WB_ALU: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = ST_WB_MEM;
        end
        ST_WB_MEM: begin
          reg_write     = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req       = 1'b1;
          iord          = 1'b1;
          mem_we        = 1'b1;
          instr_retired = mem_ready;
          if (mem_ready) state_d = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_RS2;
          ALUOp         = ALUOP_SUB;
          pc_src        = 1'b1;
          pc_write_cond = 1'b1;
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
        ST_TRAP: begin
          trap = 1'b1;
        end
        default: state_d = ST_FETCH;
      endcase
      // Expiry already implies an outstanding request with mem_ready low.
      if (tmo_expired) begin
        state_d = ST_TRAP;
        cause_d = TRAP_MEM_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - table-driven cycle-by-cycle check of the main control FSM.
module tb_multicycle_main_control;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1111111;

  // Field order: pcw pcwc pcsrc irw | req we iord srca | srcb | aluop | kill rw m2r ret | trap | cause
  localparam logic [18:0] O_ZERO    = 19'b0000_0000_00_00_0000_0_00;
  localparam logic [18:0] O_FETCH_W = 19'b0000_1000_01_00_0000_0_00;
  localparam logic [18:0] O_FETCH_R = 19'b1001_1000_01_00_0000_0_00;
  localparam logic [18:0] O_DEC     = 19'b0000_0000_00_00_0000_0_00;
  localparam logic [18:0] O_EXR     = 19'b0000_0001_00_10_0000_0_00;
  localparam logic [18:0] O_EXI_K   = 19'b0000_0001_10_10_1000_0_00;
  localparam logic [18:0] O_EXI     = 19'b0000_0001_10_10_0000_0_00;
  localparam logic [18:0] O_WBA     = 19'b0000_0000_00_00_0101_0_00;
  localparam logic [18:0] O_MADDR   = 19'b0000_0001_10_00_0000_0_00;
  localparam logic [18:0] O_MRD     = 19'b0000_1010_00_00_0000_0_00;
  localparam logic [18:0] O_WBM     = 19'b0000_0000_00_00_0111_0_00;
  localparam logic [18:0] O_MWR_W   = 19'b0000_1110_00_00_0000_0_00;
  localparam logic [18:0] O_MWR_R   = 19'b0000_1110_00_00_0001_0_00;
  localparam logic [18:0] O_BR      = 19'b0110_0001_00_01_0001_0_00;
  localparam logic [18:0] O_TRAP_IL = 19'b0000_0000_00_00_0000_1_01;
  localparam logic [18:0] O_TRAP_TO = 19'b0000_0000_00_00_0000_1_10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, iord, alu_src_a;
  logic [1:0] alu_src_b, ALUOp, trap_cause;
  logic       alu_funct7_kill, reg_write, mem_to_reg, instr_retired, trap;
  logic [18:0] act;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .funct3         (funct3),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .pc_src         (pc_src),
    .ir_write       (ir_write),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .iord           (iord),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .ALUOp          (ALUOp),
    .alu_funct7_kill(alu_funct7_kill),
    .reg_write      (reg_write),
    .mem_to_reg     (mem_to_reg),
    .instr_retired  (instr_retired),
    .trap           (trap),
    .trap_cause     (trap_cause)
  );

  assign act = {pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, iord, alu_src_a,
                alu_src_b, ALUOp, alu_funct7_kill, reg_write, mem_to_reg, instr_retired,
                trap, trap_cause};

  typedef struct packed {
    logic        r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic rdy, input logic [18:0] exp);
    vec_t v;
    v.r = r; v.op = op; v.f3 = f3; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Reset, then run one instruction with zero-wait memory and count cycles to retirement.
  task automatic measure(input string name, input logic [6:0] op, input int want);
    int n;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; opcode = op; funct3 = 3'b000; mem_ready = 1'b1;
    n = 1;
    while (!instr_retired && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    applied++;
    if (n != want) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, want);
    end
    @(posedge clk); #1;
    applied++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL %s refetch: mem_req got %b, expected 1", name, mem_req);
    end
  endtask

  initial begin
    add(1, 7'd0, 3'd0, 0, O_ZERO);
    add(1, 7'd0, 3'd0, 1, O_ZERO);
    // ADD, ready held high everywhere
    add(0, R, 3'd0, 1, O_FETCH_R); add(0, R, 3'd0, 1, O_DEC);
    add(0, R, 3'd0, 1, O_EXR);     add(0, R, 3'd0, 1, O_WBA);
    // ADDI then SLTI
    add(0, I, 3'd0, 1, O_FETCH_R); add(0, I, 3'd0, 0, O_DEC);
    add(0, I, 3'd0, 0, O_EXI_K);   add(0, I, 3'd0, 0, O_WBA);
    add(0, I, 3'd2, 1, O_FETCH_R); add(0, I, 3'd2, 0, O_DEC);
    add(0, I, 3'd2, 0, O_EXI);     add(0, I, 3'd2, 0, O_WBA);
    // LW with three wait cycles
    add(0, LW, 3'd2, 1, O_FETCH_R); add(0, LW, 3'd2, 0, O_DEC);
    add(0, LW, 3'd2, 0, O_MADDR);
    for (int i = 0; i < 3; i++) add(0, LW, 3'd2, 0, O_MRD);
    add(0, LW, 3'd2, 1, O_MRD);    add(0, LW, 3'd2, 0, O_WBM);
    // SW with one wait
    add(0, SW, 3'd2, 1, O_FETCH_R); add(0, SW, 3'd2, 0, O_DEC);
    add(0, SW, 3'd2, 0, O_MADDR);   add(0, SW, 3'd2, 0, O_MWR_W);
    add(0, SW, 3'd2, 1, O_MWR_R);
    // BEQ after one fetch wait; funct3 ignored
    add(0, BEQ, 3'd1, 0, O_FETCH_W); add(0, BEQ, 3'd1, 1, O_FETCH_R);
    add(0, BEQ, 3'd1, 0, O_DEC);     add(0, BEQ, 3'd1, 1, O_BR);
    // illegal opcode, trap held 20 cycles, then 1-cycle reset
    add(0, ILL, 3'd0, 1, O_FETCH_R); add(0, ILL, 3'd0, 0, O_DEC);
    for (int i = 0; i < 20; i++) add(0, ILL, 3'd0, logic'(i[0]), O_TRAP_IL);
    add(1, ILL, 3'd0, 0, O_ZERO);
    // fetch timeout with limit 4
    for (int i = 0; i < 5; i++) add(0, R, 3'd0, 0, O_FETCH_W);
    add(0, R, 3'd0, 0, O_TRAP_TO); add(0, R, 3'd0, 1, O_TRAP_TO);
    add(1, R, 3'd0, 0, O_ZERO);
    // ready arrives exactly on the expiry cycle
    for (int i = 0; i < 4; i++) add(0, R, 3'd0, 0, O_FETCH_W);
    add(0, R, 3'd0, 1, O_FETCH_R); add(0, R, 3'd0, 0, O_DEC);
    add(0, R, 3'd0, 0, O_EXR);     add(0, R, 3'd0, 0, O_WBA);
    // reset in the middle of a load
    add(0, LW, 3'd2, 1, O_FETCH_R); add(0, LW, 3'd2, 0, O_DEC);
    add(0, LW, 3'd2, 0, O_MADDR);   add(0, LW, 3'd2, 0, O_MRD);
    add(1, LW, 3'd2, 0, O_ZERO);
    add(0, R, 3'd0, 1, O_FETCH_R);  add(0, R, 3'd0, 0, O_DEC);
    add(0, R, 3'd0, 0, O_EXR);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].r; opcode = vecs[i].op; funct3 = vecs[i].f3; mem_ready = vecs[i].rdy;
      @(negedge clk);
      applied++;
      if (act !== vecs[i].exp) begin
        miscompares++;
        $display("FAIL vec%0d outputs: got %b, expected %b", i, act, vecs[i].exp);
      end
    end

    measure("add", R, 4);
    measure("beq", BEQ, 3);
    measure("sw", SW, 4);
    measure("lw", LW, 5);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
